// File: rtl/datamover_pkg.sv
// Shared types and constants for the memory-to-stream datamover.
package datamover_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  localparam int         MIN_PKT_BYTES = 16;
  localparam int         MAX_PKT_BYTES = 1600;
  localparam int         AXI_4K        = 4096;
  localparam logic [1:0] BURST_INCR    = 2'b01;

endpackage

// File: rtl/datamover_if.sv
// Descriptor, AXI4 read (AR/R), AXI-Stream and error signals of the datamover.
// Every channel transfers on a clock edge where its valid and ready are both 1;
// a source holds valid and its payload stable until that transfer happens.
interface datamover_if #(parameter int DATA_WIDTH = 32);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [31:0]           d_addr;
  logic [10:0]           d_len;
  logic                  d_tvalid;
  logic                  d_tready;

  logic [31:0]           m_araddr;
  logic [7:0]            m_arlen;
  logic [2:0]            m_arsize;
  logic [1:0]            m_arburst;
  logic                  m_arvalid;
  logic                  m_arready;

  logic [DATA_WIDTH-1:0] m_rdata;
  logic [1:0]            m_rresp;
  logic                  m_rlast;
  logic                  m_rvalid;
  logic                  m_rready;

  logic [DATA_WIDTH-1:0] s_tdata;
  logic [BYTES-1:0]      s_tkeep;
  logic                  s_tlast;
  logic                  s_tvalid;
  logic                  s_tready;

  logic                  err;

  modport master (
    input  d_addr, d_len, d_tvalid,
    output d_tready,
    output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready,
    output s_tdata, s_tkeep, s_tlast, s_tvalid,
    input  s_tready,
    output err
  );

  modport slave (
    output d_addr, d_len, d_tvalid,
    input  d_tready,
    input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready,
    input  s_tdata, s_tkeep, s_tlast, s_tvalid,
    output s_tready,
    input  err
  );

endinterface

// File: rtl/datamover_axis_out_reg.sv
// Single register stage driving the AXI-Stream output; a beat is loaded only
// when the stage is empty or being drained in the same cycle.
module axis_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_keep,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   s_tdata,
  output logic [DATA_WIDTH/8-1:0] s_tkeep,
  output logic                    s_tlast,
  output logic                    s_tvalid,
  input  logic                    s_tready
);

  assign in_ready = !s_tvalid || s_tready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_tdata  <= '0;
      s_tkeep  <= '0;
      s_tlast  <= 1'b0;
      s_tvalid <= 1'b0;
    end else if (in_valid) begin
      s_tdata  <= in_data;
      s_tkeep  <= in_keep;
      s_tlast  <= in_last;
      s_tvalid <= 1'b1;
    end else if (s_tready) begin
      s_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/datamover_out.sv
// Reads one packet per descriptor through AXI4 INCR bursts (never crossing 4 KB)
// and emits it as a single AXI-Stream packet.
module datamover_out
  import datamover_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic   clk,
  input  logic   reset_n,
  datamover_if.master bus,
  output state_t dbg_state
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);

  state_t            state, state_next;
  logic [31:0]       addr_q;
  logic [10:0]       rem_q;
  logic [8:0]        burst_q, beat_q;
  logic [BYTES-1:0]  last_keep_q, keep_c;
  logic              arvalid_q, d_ready_q, err_q;
  logic [31:0]       araddr_q;
  logic [7:0]        arlen_q;
  logic [11:0]       len_plus;
  logic [12:0]       to_4k, blen;
  logic              desc_hs, len_ok, ar_hs, r_hs, burst_final, pkt_final, out_ready;

  assign desc_hs     = bus.d_tvalid && d_ready_q;
  assign len_ok      = (bus.d_len >= 11'(MIN_PKT_BYTES)) && (bus.d_len <= 11'(MAX_PKT_BYTES));
  assign ar_hs       = (state == AR) && arvalid_q && bus.m_arready;
  assign r_hs        = bus.m_rvalid && bus.m_rready;
  assign burst_final = (beat_q == burst_q - 9'd1);
  assign pkt_final   = (rem_q == 11'd1);
  assign len_plus    = {1'b0, bus.d_len} + 12'(BYTES - 1);

  // Tail keep: low (len mod BYTES) lanes, or all lanes for an exact multiple.
  always_comb begin
    keep_c = '0;
    for (int i = 0; i < BYTES; i++)
      keep_c[i] = (bus.d_len[SZ-1:0] == '0) || (i < int'(bus.d_len[SZ-1:0]));
  end

  always_comb begin
    to_4k = (13'(AXI_4K) - {1'b0, addr_q[11:0]}) >> SZ;
    blen  = {2'b00, rem_q};
    if (blen > 13'(MAX_BURST)) blen = 13'(MAX_BURST);
    if (blen > to_4k)          blen = to_4k;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (desc_hs && len_ok) state_next = AR;
      AR:      if (ar_hs) state_next = R;
      R:       if (r_hs && burst_final) state_next = pkt_final ? IDLE : AR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      rem_q       <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      last_keep_q <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      d_ready_q <= (state_next == IDLE);
      err_q     <= (desc_hs && !len_ok) ||
                   (r_hs && ((bus.m_rresp != 2'b00) || (bus.m_rlast != burst_final)));
      if (desc_hs && len_ok) begin
        addr_q      <= bus.d_addr & ~32'(BYTES - 1);
        rem_q       <= 11'(len_plus >> SZ);
        last_keep_q <= keep_c;
      end
      // The burst is sized in the first AR cycle and presented from the second.
      if ((state == AR) && !arvalid_q) begin
        arvalid_q <= 1'b1;
        araddr_q  <= addr_q;
        arlen_q   <= 8'(blen - 13'd1);
      end else if (ar_hs) begin
        arvalid_q <= 1'b0;
        burst_q   <= {1'b0, arlen_q} + 9'd1;
        beat_q    <= '0;
      end
      if (r_hs) begin
        beat_q <= beat_q + 9'd1;
        rem_q  <= rem_q - 11'd1;
        if (burst_final) addr_q <= addr_q + (32'(burst_q) << SZ);
      end
    end
  end

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (r_hs),
    .in_data  (bus.m_rdata),
    .in_keep  (pkt_final ? last_keep_q : {BYTES{1'b1}}),
    .in_last  (pkt_final),
    .in_ready (out_ready),
    .s_tdata  (bus.s_tdata),
    .s_tkeep  (bus.s_tkeep),
    .s_tlast  (bus.s_tlast),
    .s_tvalid (bus.s_tvalid),
    .s_tready (bus.s_tready)
  );

  assign bus.d_tready  = d_ready_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = arlen_q;
  assign bus.m_arsize  = 3'(SZ);
  assign bus.m_arburst = BURST_INCR;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = (state == R) && out_ready;
  assign bus.err       = err_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_datamover_out.sv
// Bench for datamover_out: descriptor table with hand-computed results, an AXI
// read slave backed by an address-derived memory, and a stream scoreboard.
module tb_datamover_out;
  import datamover_pkg::*;

  localparam int DW = 32;
  localparam int W  = DW + 4 + 1;
  localparam int NV = 12;

  typedef struct {
    logic [31:0] addr;
    logic [10:0] len;
    int          ready_pct;
    int          ar_stall;
    int          r_stall;
    int          resp_beat;
    bit          early;
    int          exp_ars;
    int          exp_beats;
    logic [3:0]  exp_keep;
    int          exp_err;
  } vec_t;

  logic   clk = 1'b0;
  logic   reset_n;
  state_t dbg_state;

  datamover_if #(.DATA_WIDTH(DW)) bus ();

  datamover_out #(.DATA_WIDTH(DW), .MAX_BURST(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int beat_cnt, ar_cnt, err_cnt;
  int ready_pct = 100, ar_stall = 0, r_stall = 0, resp_beat = -1, pkt_beat = 0;
  bit early_en = 0, first_burst = 0;
  logic [W-1:0]  exp_q[$];
  logic [39:0]   ar_exp_q[$];
  logic [39:0]   pend_q[$];
  vec_t          vecs[NV];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [31:0] a0, input int len, input logic [3:0] last_keep);
    logic [31:0] a;
    int beats, rem, n, to4k;
    a = a0 & 32'hFFFF_FFFC;
    beats = (len + 3) / 4;
    for (int i = 0; i < beats; i++) begin
      logic [31:0] wa;
      wa = a + 32'(i * 4);
      exp_q.push_back({mem_word(wa), (i == beats - 1) ? last_keep : 4'hF, i == beats - 1});
    end
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 4;
      n = rem;
      if (n > 16)   n = 16;
      if (n > to4k) n = to4k;
      ar_exp_q.push_back({a, 8'(n - 1)});
      a = a + 32'(n * 4);
      rem -= n;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_d_tready"},  bus.d_tready, 0);
    chk({tag, "_arvalid"},   bus.m_arvalid, 0);
    chk({tag, "_araddr"},    bus.m_araddr, 0);
    chk({tag, "_arlen"},     bus.m_arlen, 0);
    chk({tag, "_arsize"},    bus.m_arsize, 3'd2);
    chk({tag, "_arburst"},   bus.m_arburst, 2'b01);
    chk({tag, "_rready"},    bus.m_rready, 0);
    chk({tag, "_tvalid"},    bus.s_tvalid, 0);
    chk({tag, "_tdata"},     bus.s_tdata, 0);
    chk({tag, "_tkeep"},     bus.s_tkeep, 0);
    chk({tag, "_tlast"},     bus.s_tlast, 0);
    chk({tag, "_err"},       bus.err, 0);
    chk({tag, "_state"},     dbg_state, IDLE);
  endtask

  task automatic send_desc(input logic [31:0] a, input logic [10:0] len);
    int budget;
    @(posedge clk); #1;
    bus.d_addr = a; bus.d_len = len; bus.d_tvalid = 1'b1;
    budget = 0;
    do begin @(negedge clk); budget++; end while (!bus.d_tready && budget < 2000);
    if (!bus.d_tready) chk("desc_accept_timeout", 0, 1);
    @(posedge clk); #1;
    bus.d_tvalid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int budget;
    ready_pct = v.ready_pct; ar_stall = v.ar_stall; r_stall = v.r_stall;
    resp_beat = v.resp_beat; early_en = v.early; first_burst = 1; pkt_beat = 0;
    beat_cnt = 0; ar_cnt = 0; err_cnt = 0;
    if (v.exp_ars > 0) push_expected(v.addr, int'(v.len), v.exp_keep);
    send_desc(v.addr, v.len);
    repeat (4) @(negedge clk);
    budget = 0;
    while (!(exp_q.size() == 0 && ar_exp_q.size() == 0 && bus.d_tready) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20000) begin
      chk($sformatf("v%0d_completion_timeout", idx), 0, 1);
      exp_q.delete(); ar_exp_q.delete();
    end
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_ar_count", idx),   ar_cnt,   v.exp_ars);
    chk($sformatf("v%0d_beat_count", idx), beat_cnt, v.exp_beats);
    chk($sformatf("v%0d_err_cycles", idx), err_cnt,  v.exp_err);
  endtask

  // AXI read slave: queues accepted ARs and returns their beats in order.
  initial begin : axi_slave
    logic r_fire, ar_fire, busy;
    logic [39:0] ar_info;
    logic [31:0] base;
    int idx, blen;
    bit early_now;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0; bus.m_rlast = 0;
    busy = 0; idx = 0; blen = 0; base = 0; early_now = 0;
    forever begin
      @(negedge clk);
      r_fire  = bus.m_rvalid && bus.m_rready;
      ar_fire = bus.m_arvalid && bus.m_arready;
      ar_info = {bus.m_araddr, bus.m_arlen};
      @(posedge clk); #1;
      if (!reset_n) begin
        pend_q.delete(); busy = 0;
        bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_rresp = 0; bus.m_arready = 0;
      end else begin
        if (ar_fire) pend_q.push_back(ar_info);
        if (r_fire) begin
          pkt_beat++;
          if (idx == blen) busy = 0;
          else idx++;
        end
        if (!busy && pend_q.size() > 0) begin
          ar_info = pend_q.pop_front();
          base = ar_info[39:8]; blen = int'(ar_info[7:0]); idx = 0; busy = 1;
          early_now = early_en && first_burst; first_burst = 0;
        end
        if (!(bus.m_rvalid && !r_fire)) begin
          bus.m_rvalid = busy && ($urandom_range(0, 99) >= r_stall);
          bus.m_rdata  = mem_word(base + 32'(idx * 4));
          bus.m_rresp  = (pkt_beat == resp_beat) ? 2'b10 : 2'b00;
          bus.m_rlast  = early_now ? (idx == blen - 1) : (idx == blen);
        end
        bus.m_arready = ($urandom_range(0, 99) >= ar_stall);
      end
    end
  end

  initial begin : stream_sink
    bus.s_tready = 0;
    forever begin
      @(posedge clk); #1;
      bus.s_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  initial begin : monitor
    logic prev_sv, prev_sr, prev_av, prev_ar;
    logic [W-1:0] prev_s, got;
    logic [39:0] prev_a, ga;
    bit new_beat;
    prev_sv = 0; prev_sr = 0; prev_av = 0; prev_ar = 0; prev_s = '0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_sv = 0; prev_av = 0;
      end else begin
        got = {bus.s_tdata, bus.s_tkeep, bus.s_tlast};
        ga  = {bus.m_araddr, bus.m_arlen};
        if (prev_sv && !prev_sr) begin
          chk("s_hold_valid", bus.s_tvalid, 1);
          chk("s_hold_payload", got, prev_s);
        end
        new_beat = bus.s_tvalid && (!prev_sv || prev_sr);
        if (new_beat && bus.s_tlast) chk("d_tready_after_last", bus.d_tready, 1);
        if (bus.s_tvalid && bus.s_tready) begin
          beat_cnt++;
          if (exp_q.size() == 0) chk("stream_unexpected_beat", got, 0);
          else chk("stream_beat", got, exp_q.pop_front());
        end
        if (prev_av && !prev_ar) begin
          chk("ar_hold_valid", bus.m_arvalid, 1);
          chk("ar_hold_payload", ga, prev_a);
        end
        if (bus.m_arvalid && bus.m_arready) begin
          ar_cnt++;
          if (ar_exp_q.size() == 0) chk("ar_unexpected", ga, 0);
          else chk("ar_addr_len", ga, ar_exp_q.pop_front());
        end
        if (bus.err) err_cnt++;
        prev_sv = bus.s_tvalid; prev_sr = bus.s_tready; prev_s = got;
        prev_av = bus.m_arvalid; prev_ar = bus.m_arready; prev_a = ga;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    n_fail++;
    $display("FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : main
    int budget;
    reset_n = 1'b0;
    bus.d_tvalid = 0; bus.d_addr = 0; bus.d_len = 0;

    //             addr          len  rdy  ars  rs  resp  erl  ars beats keep    err
    vecs[0]  = '{32'h0000_1000, 11'd64,   100, 0,  0,  -1, 0,  1,  16, 4'hF,    0};
    vecs[1]  = '{32'h0000_2000, 11'd1600, 100, 0,  0,  -1, 0, 25, 400, 4'hF,    0};
    vecs[2]  = '{32'h0000_0FF0, 11'd37,   100, 0,  0,  -1, 0,  2,  10, 4'b0001, 0};
    vecs[3]  = '{32'h0000_3002, 11'd18,   100, 20, 20, -1, 0,  1,   5, 4'b0011, 0};
    vecs[4]  = '{32'h0000_4FC0, 11'd200,  30,  50, 40, -1, 0,  4,  50, 4'hF,    0};
    vecs[5]  = '{32'h0000_5000, 11'd8,    100, 0,  0,  -1, 0,  0,   0, 4'hF,    1};
    vecs[6]  = '{32'h0000_5000, 11'd1601, 100, 0,  0,  -1, 0,  0,   0, 4'hF,    1};
    vecs[7]  = '{32'h0000_6000, 11'd16,   100, 0,  0,  -1, 0,  1,   4, 4'hF,    0};
    vecs[8]  = '{32'h0000_7000, 11'd1599, 30,  30, 30, -1, 0, 25, 400, 4'b0111, 0};
    vecs[9]  = '{32'h0000_1000, 11'd64,   60,  0,  0,   7, 0,  1,  16, 4'hF,    1};
    vecs[10] = '{32'h0000_0FF0, 11'd37,   100, 0,  0,  -1, 1,  2,  10, 4'b0001, 2};
    vecs[11] = '{32'h0000_0FFC, 11'd16,   100, 0,  0,  -1, 0,  2,   4, 4'hF,    0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset on the fifth beat of a 64-byte packet, then a clean 16-byte packet.
    ready_pct = 100; ar_stall = 0; r_stall = 0; resp_beat = -1; early_en = 0;
    first_burst = 1; pkt_beat = 0; beat_cnt = 0;
    push_expected(32'h0000_8000, 64, 4'hF);
    send_desc(32'h0000_8000, 11'd64);
    budget = 0;
    while (beat_cnt < 5 && budget < 2000) begin
      @(negedge clk); #1;
      budget++;
    end
    if (beat_cnt < 5) chk("reset_seq_beat5_timeout", beat_cnt, 5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete(); ar_exp_q.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_vec('{32'h0000_9000, 11'd16, 100, 0, 0, -1, 0, 1, 4, 4'hF, 0}, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/datamover_out.md
DATAMOVER_OUT -- requirements
Module: datamover_out

Interface
REQ-001 Parameter DATA_WIDTH, default 32, meaning stream and AXI data width in bits; legal values 32, 64, 128; BYTES = DATA_WIDTH/8.
REQ-002 Parameter MAX_BURST, default 16, meaning maximum beats per AXI read burst; legal values are powers of two from 2 to 256.
REQ-003 Ports, one per line:
- clk  in  1  clock; reset_n  in  1  reset, asynchronous, active-low.
- d_addr  in  32  packet start address; d_len  in  11  packet length in bytes; d_tvalid  in  1  descriptor valid; d_tready  out  1  descriptor accepted.
- m_araddr  out  32  burst address; m_arlen  out  8  beats-1; m_arsize  out  3  log2(BYTES); m_arburst  out  2  burst type; m_arvalid  out  1; m_arready  in  1.
- m_rdata  in  DATA_WIDTH; m_rresp  in  2; m_rlast  in  1; m_rvalid  in  1; m_rready  out  1.
- s_tdata  out  DATA_WIDTH; s_tkeep  out  BYTES; s_tlast  out  1; s_tvalid  out  1; s_tready  in  1.
- err  out  1  one-cycle error pulse.

Function
REQ-004 The block SHALL read each packet described by one descriptor from memory through AXI4 INCR bursts and emit it as a single AXI-Stream packet, in descriptor order.
REQ-005 The FSM SHALL use states IDLE, AR, R.
- IDLE -> AR on a descriptor handshake.
- AR -> R on an m_arvalid/m_arready handshake.
- R -> AR on the burst-final R beat when beats remain.
- R -> IDLE on the packet-final R beat.
REQ-006 d_tready SHALL be 1 only in IDLE; d_addr SHALL be captured with bits [log2(BYTES)-1:0] forced to 0.
REQ-007 A descriptor with d_len < 16 or d_len > 1600 SHALL be consumed, generate no AXI traffic, pulse err, and leave the FSM in IDLE.
REQ-008 Total beats SHALL be ceil(d_len/BYTES), held in an 11-bit remaining-beat counter.
REQ-009 Each burst length SHALL be min(remaining beats, MAX_BURST, beats to the next 4 KB boundary); no burst SHALL cross a 4 KB boundary.
REQ-010 The block SHALL keep exactly one AR outstanding; the next burst address SHALL be the previous address + beats*BYTES.
REQ-011 m_arvalid SHALL be driven from a register, held with stable m_araddr/m_arlen until m_arready, and set the cycle after entry to AR.
REQ-012 m_arsize SHALL equal log2(BYTES) and m_arburst SHALL equal 2'b01 at all times.
REQ-013 The output SHALL be a single register stage with m_rready = (R state) and (!s_tvalid or s_tready); an R beat SHALL appear on s_tdata one cycle after its handshake.
REQ-014 s_tkeep SHALL be all ones except on the packet-final beat, where its low (d_len mod BYTES) bits are set, or all bits when the remainder is 0.
REQ-015 s_tlast SHALL be 1 only on the packet-final beat.
REQ-016 Once s_tvalid is asserted, s_tdata, s_tkeep and s_tlast SHALL stay stable until s_tready.
REQ-017 An m_rresp != 0 on any beat SHALL pulse err; the data SHALL still be forwarded and the packet completed.
REQ-018 Burst end SHALL be determined by the internal beat counter.
- m_rlast disagreeing with the counter SHALL pulse err.
- An m_rlast early by one or more beats SHALL not shorten the packet.
REQ-019 A new descriptor SHALL be accepted in the cycle after the packet-final R handshake, even while that beat is still held on the stream output.

Reset
REQ-020 While reset_n is low, the FSM SHALL be in IDLE and every output SHALL be 0, except m_arsize and m_arburst, which keep their constant values.
REQ-021 Assertion of reset mid-packet SHALL abandon the packet without emitting s_tlast; the surrounding interconnect is reset together with the block.

Structure
REQ-022 Package datamover_pkg SHALL hold:
- the state enum;
- constants MIN_PKT_BYTES=16, MAX_PKT_BYTES=1600, AXI_4K=4096 and BURST_INCR=2'b01.
REQ-023 The output register stage SHALL be sub-module axis_out_reg, parameterised by DATA_WIDTH.

Verification
REQ-024 Descriptor addr 0x1000, len 64, DATA_WIDTH 32 -> one AR with arlen 15; 16 stream beats, tkeep 4'hF throughout, tlast on beat 16.
REQ-025 Descriptor addr 0x2000, len 1600, MAX_BURST 16 -> 25 ARs at addresses 0x2000 + n*64, each arlen 15; tlast only on beat 400.
REQ-026 Descriptor addr 0x0FF0, len 37 -> AR 0x0FF0 arlen 3, then AR 0x1000 arlen 5; final beat tkeep 4'b0001.
REQ-027 Random s_tready at 30% and random m_arready/m_rvalid stalls -> data matches the memory model, no beat lost or duplicated, outputs stable while stalled.
REQ-028 Descriptors of len 8 and len 1601, followed by len 16 -> two err pulses with no AR for the bad descriptors; len 16 completes normally.
REQ-029 Reset asserted on beat 5 of a 64-byte packet -> all outputs 0 during reset; a following 16-byte packet completes correctly.
